// File: rtl/lz_norm_pipe_pkg.sv
// Shared fp helpers: width arithmetic and count-encoding constants used by the
// leading-zero counter and the normalise pipeline.
package lz_norm_pipe_pkg;

    // Count bias applied on top of the raw leading-zero count.
    localparam int unsigned CNT_BIAS_LZ       = 0;
    localparam int unsigned CNT_BIAS_PLUS_ONE = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Raw count spans 0..width, so it needs width+1 codes.
    function automatic int unsigned lz_width(input int unsigned width);
        return clog2(width + 1);
    endfunction

    // Output count spans 0..width+1 to cover the plus-one encoding.
    function automatic int unsigned cnt_width(input int unsigned width);
        return clog2(width + 2);
    endfunction

    function automatic int unsigned cnt_bias(input bit plus_one);
        return plus_one ? CNT_BIAS_PLUS_ONE : CNT_BIAS_LZ;
    endfunction

endpackage

// File: rtl/lzc_tree.sv
// Recursive leading-zero counter: splits the operand into upper/lower halves and
// combines the half counts, so any width (not just powers of two) is handled.
module lzc_tree
    import lz_norm_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 48,
    localparam int unsigned CW = lz_width(WIDTH)
) (
    input  logic [WIDTH-1:0] in_bits,
    output logic [CW-1:0]    cnt,
    output logic             zero
);

    if (WIDTH == 1) begin : g_leaf
        assign cnt  = CW'(~in_bits[0]);
        assign zero = ~in_bits[0];
    end else begin : g_node
        localparam int unsigned HW = WIDTH - WIDTH / 2;
        localparam int unsigned LW = WIDTH / 2;

        logic [lz_width(HW)-1:0] hi_cnt;
        logic [lz_width(LW)-1:0] lo_cnt;
        logic                    hi_zero;
        logic                    lo_zero;

        lzc_tree #(.WIDTH(HW)) u_hi (
            .in_bits(in_bits[WIDTH-1 -: HW]),
            .cnt    (hi_cnt),
            .zero   (hi_zero)
        );

        lzc_tree #(.WIDTH(LW)) u_lo (
            .in_bits(in_bits[LW-1:0]),
            .cnt    (lo_cnt),
            .zero   (lo_zero)
        );

        // Only look at the lower half once the upper half is entirely zero.
        assign cnt  = hi_zero ? CW'(HW) + CW'(lo_cnt) : CW'(hi_cnt);
        assign zero = hi_zero & lo_zero;
    end

endmodule

// File: rtl/lz_norm_pipe.sv
// Two-stage leading-zero count and normalise pipeline with valid/ready flow
// control: S1 counts, S2 shifts the operand so its MSB is set.
module lz_norm_pipe
    import lz_norm_pipe_pkg::*;
#(
    parameter int unsigned WIDTH    = 48,
    parameter int unsigned TAG_W    = 8,
    parameter bit          PLUS_ONE = 1'b1,
    localparam int unsigned CNT_W   = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_q,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_cnt,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LZ_W = lz_width(WIDTH);

    logic [LZ_W-1:0]  lz_cnt;
    logic             lz_zero;

    logic             s1_valid_q;
    logic [LZ_W-1:0]  s1_lz_q;
    logic             s1_zero_q;
    logic [WIDTH-1:0] s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q;
    logic [CNT_W-1:0] s2_cnt_q;
    logic [WIDTH-1:0] s2_norm_q;
    logic             s2_zero_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic             s2_free;
    logic [WIDTH-1:0] shifted;

    lzc_tree #(.WIDTH(WIDTH)) u_lzc (
        .in_bits(in_q),
        .cnt    (lz_cnt),
        .zero   (lz_zero)
    );

    // S2 can take a new entry when empty or when its result leaves this cycle.
    assign s2_free  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_lz_q    <= '0;
            s1_zero_q  <= 1'b0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_lz_q   <= lz_cnt;
                s1_zero_q <= lz_zero;
                s1_op_q   <= in_q;
                s1_tag_q  <= in_tag;
            end
        end
    end

    // Log2-staged barrel shift; a zero operand has lz=WIDTH and shifts out fully.
    always_comb begin
        shifted = s1_op_q;
        for (int k = 0; k < int'(LZ_W); k++) begin
            if (s1_lz_q[k]) begin
                shifted = shifted << (32'd1 << k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_cnt_q   <= '0;
            s2_norm_q  <= '0;
            s2_zero_q  <= 1'b0;
            s2_tag_q   <= '0;
        end else if (s2_free) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_cnt_q  <= CNT_W'(s1_lz_q) + CNT_W'(cnt_bias(PLUS_ONE));
                s2_norm_q <= shifted;
                s2_zero_q <= s1_zero_q;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_cnt   = s2_cnt_q;
    assign out_norm  = s2_norm_q;
    assign out_zero  = s2_zero_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_lz_norm_pipe.sv
// Bench for lz_norm_pipe: directed vectors, back-to-back, backpressure, reset
// flush and randomized traffic against a queue-based reference model.
module tb_lz_norm_pipe;

    localparam int W = 48;
    localparam int T = 8;
    localparam int C = 6;

    typedef struct {
        logic [W-1:0] q;
        logic [T-1:0] tag;
    } op_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_q = '0;
    logic [T-1:0] in_tag = '0;
    logic         out_ready = 1'b0;

    logic         in_ready, out_valid, out_zero;
    logic [C-1:0] out_cnt;
    logic [W-1:0] out_norm;
    logic [T-1:0] out_tag;

    logic         in_ready0, out_valid0, out_zero0;
    logic [C-1:0] out_cnt0;
    logic [W-1:0] out_norm0;
    logic [T-1:0] out_tag0;

    int checks = 0;
    int failures = 0;
    op_t sb[$];

    always #5 clk = ~clk;

    lz_norm_pipe #(.WIDTH(W), .TAG_W(T), .PLUS_ONE(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt),
        .out_norm(out_norm), .out_zero(out_zero), .out_tag(out_tag)
    );

    lz_norm_pipe #(.WIDTH(W), .TAG_W(T), .PLUS_ONE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_q(in_q),
        .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready), .out_cnt(out_cnt0),
        .out_norm(out_norm0), .out_zero(out_zero0), .out_tag(out_tag0)
    );

    // Reference: count zeros from the MSB down.
    function automatic int ref_lz(input logic [W-1:0] q);
        int n = 0;
        while (n < W && q[W-1-n] == 1'b0) n++;
        return n;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if ($urandom_range(0, 19) == 0) return '0;
        return r[W-1:0] >> $urandom_range(0, W);
    endfunction

    // Apply inputs away from the clock edge and report this cycle's handshakes.
    task automatic drive(input logic v, input logic [W-1:0] q, input logic [T-1:0] t,
                         input logic r, output logic acc, output logic dlv);
        @(negedge clk);
        in_valid = v;
        in_q = q;
        in_tag = t;
        out_ready = r;
        #1;
        acc = in_valid && in_ready;
        dlv = out_valid && out_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_cnt !== '0 || out_norm !== '0 || out_zero !== 1'b0 ||
            out_tag !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b cnt=%0d norm=%h zero=%b tag=%h, want all 0",
                     out_valid, out_cnt, out_norm, out_zero, out_tag);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] dq[3]    = '{48'h8000_0000_0000, 48'h0000_0000_0001, 48'h0};
        logic [T-1:0] dt[3]    = '{8'h3C, 8'hA5, 8'h5A};
        int           dcnt[3]  = '{1, 48, 49};
        int           dcnt0[3] = '{0, 47, 48};
        logic [W-1:0] dnorm[3] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 48'h0};
        logic         dzero[3] = '{1'b0, 1'b0, 1'b1};
        logic         acc, dlv;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, dq[i], dt[i], 1'b1, acc, dlv);
            checks++;
            if (!acc) begin
                failures++;
                $display("FAIL dir_accept[%0d]: in_ready=%b want 1", i, in_ready);
            end
            drive(1'b0, '0, '0, 1'b1, acc, dlv);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL dir_latency_early[%0d]: out_valid=%b want 0", i, out_valid);
            end
            drive(1'b0, '0, '0, 1'b1, acc, dlv);
            checks++;
            if (out_valid !== 1'b1 || out_cnt !== C'(dcnt[i]) || out_norm !== dnorm[i] ||
                out_zero !== dzero[i] || out_tag !== dt[i] || out_cnt0 !== C'(dcnt0[i])) begin
                failures++;
                $display("FAIL dir_result[%0d]: v=%b cnt=%0d norm=%h zero=%b tag=%h cnt0=%0d, want v=1 cnt=%0d norm=%h zero=%b tag=%h cnt0=%0d",
                         i, out_valid, out_cnt, out_norm, out_zero, out_tag, out_cnt0,
                         dcnt[i], dnorm[i], dzero[i], dt[i], dcnt0[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] bq[3] = '{48'h0000_00F0_0000, 48'h0000_0000_0300, 48'h0400_0000_0000};
        int           bc[3] = '{25, 39, 6};
        int           got = 0;
        logic         acc, dlv;
        for (int c = 0; c < 6; c++) begin
            drive(c < 3, (c < 3) ? bq[c] : '0, T'(c), 1'b1, acc, dlv);
            if (c < 3) begin
                checks++;
                if (!acc) begin
                    failures++;
                    $display("FAIL b2b_accept[%0d]: in_ready=%b want 1", c, in_ready);
                end
            end
            if (c >= 2 && c < 5) begin
                checks++;
                if (!dlv || out_cnt !== C'(bc[got]) || out_tag !== T'(got)) begin
                    failures++;
                    $display("FAIL b2b_out[%0d]: v=%b cnt=%0d tag=%h, want v=1 cnt=%0d tag=%h",
                             got, out_valid, out_cnt, out_tag, bc[got], T'(got));
                end
                got++;
            end
        end
    endtask

    task automatic test_backpressure();
        op_t  ops[3];
        int   idx = 0, got = 0, lz;
        logic acc, dlv;
        for (int i = 0; i < 3; i++) begin
            ops[i].q = rand_op() | 48'h1;
            ops[i].tag = T'($urandom());
        end
        for (int c = 0; c < 5; c++) begin
            drive(idx < 3, ops[(idx < 3) ? idx : 2].q, ops[(idx < 3) ? idx : 2].tag, 1'b0,
                  acc, dlv);
            if (acc) idx++;
            if (out_valid) begin
                lz = ref_lz(ops[0].q);
                checks++;
                if (out_cnt !== C'(lz + 1) || out_norm !== (ops[0].q << lz) ||
                    out_tag !== ops[0].tag) begin
                    failures++;
                    $display("FAIL bp_hold[%0d]: cnt=%0d norm=%h tag=%h, want cnt=%0d norm=%h tag=%h",
                             c, out_cnt, out_norm, out_tag, lz + 1, ops[0].q << lz, ops[0].tag);
                end
            end
        end
        checks++;
        if (idx != 2 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accepts: accepted=%0d in_ready=%b, want 2 and 0", idx, in_ready);
        end
        for (int c = 0; c < 12 && got < 3; c++) begin
            drive(idx < 3, ops[(idx < 3) ? idx : 2].q, ops[(idx < 3) ? idx : 2].tag, 1'b1,
                  acc, dlv);
            if (dlv) begin
                lz = ref_lz(ops[got].q);
                checks++;
                if (out_cnt !== C'(lz + 1) || out_norm !== (ops[got].q << lz) ||
                    out_tag !== ops[got].tag) begin
                    failures++;
                    $display("FAIL bp_release[%0d]: cnt=%0d tag=%h, want cnt=%0d tag=%h",
                             got, out_cnt, out_tag, lz + 1, ops[got].tag);
                end
                got++;
            end
            if (acc) idx++;
        end
        checks++;
        if (got != 3) begin
            failures++;
            $display("FAIL bp_count: delivered=%0d want 3", got);
        end
    endtask

    task automatic test_reset_flush();
        logic acc, dlv;
        int   acc_n = 0;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, rand_op(), T'(8'hE0 + c), 1'b0, acc, dlv);
            if (acc) acc_n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_cnt !== '0 || out_tag !== '0 || acc_n != 2) begin
            failures++;
            $display("FAIL flush_rst: valid=%b cnt=%0d tag=%h accepted=%0d, want 0 0 00 2",
                     out_valid, out_cnt, out_tag, acc_n);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_in_ready: got %b want 1", in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, '0, '0, 1'b1, acc, dlv);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_stale[%0d]: out_valid=%b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_random();
        op_t  e, n;
        int   lz;
        logic acc, dlv;
        for (int c = 0; c < 600; c++) begin
            n.q = rand_op();
            n.tag = T'($urandom());
            drive($urandom_range(0, 3) != 0, n.q, n.tag, $urandom_range(0, 9) < 7, acc, dlv);
            checks++;
            if (out_valid0 !== out_valid || in_ready0 !== in_ready) begin
                failures++;
                $display("FAIL rand_twin_flow[%0d]: v=%b/%b rdy=%b/%b", c, out_valid,
                         out_valid0, in_ready, in_ready0);
            end
            if (dlv) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra[%0d]: result with empty scoreboard, tag=%h want none",
                             c, out_tag);
                end else begin
                    e = sb.pop_front();
                    lz = ref_lz(e.q);
                    if (out_cnt !== C'(lz + 1) || out_norm !== (e.q << lz) ||
                        out_zero !== (e.q == '0) || out_tag !== e.tag ||
                        out_cnt0 !== C'(lz) || out_norm0 !== (e.q << lz) ||
                        out_zero0 !== (e.q == '0) || out_tag0 !== e.tag) begin
                        failures++;
                        $display("FAIL rand_result[%0d]: q=%h cnt=%0d norm=%h zero=%b tag=%h cnt0=%0d, want cnt=%0d norm=%h zero=%b tag=%h cnt0=%0d",
                                 c, e.q, out_cnt, out_norm, out_zero, out_tag, out_cnt0,
                                 lz + 1, e.q << lz, e.q == '0, e.tag, lz);
                    end
                end
            end
            if (acc) sb.push_back(n);
        end
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            drive(1'b0, '0, '0, 1'b1, acc, dlv);
            if (dlv) begin
                e = sb.pop_front();
                lz = ref_lz(e.q);
                checks++;
                if (out_cnt !== C'(lz + 1) || out_norm !== (e.q << lz) || out_tag !== e.tag) begin
                    failures++;
                    $display("FAIL rand_drain: cnt=%0d tag=%h, want cnt=%0d tag=%h",
                             out_cnt, out_tag, lz + 1, e.tag);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rand_lost: %0d results outstanding, want 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
